// File: rtl/config_pkg.sv
// Shared FU configuration: vector geometry, fixed-point and gain formats.
// Pulled in by rms_gain and its fixed_mul_round_sat helper.
package config_pkg;

  localparam int unsigned D             = 16;
  localparam int unsigned FixedBits     = 16;
  localparam int unsigned FixedFracBits = 8;
  localparam int unsigned GainBits      = 16;
  localparam int unsigned GainFracBits  = 8;

  typedef logic signed [FixedBits-1:0] fixed_point_t;
  typedef logic signed [GainBits-1:0]  gain_t;
  typedef logic [$clog2(D)-1:0]        DI_t;

  localparam fixed_point_t FixedPointMax = {1'b0, {(FixedBits-1){1'b1}}};
  localparam fixed_point_t FixedPointMin = {1'b1, {(FixedBits-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } rms_gain_state_e;

endpackage

// File: rtl/fixed_mul_round_sat.sv
// Combinational fixed_point_t x gain_t multiply with round-half-up and
// saturation back to fixed_point_t; sat_o flags a clamped result.
module fixed_mul_round_sat
  import config_pkg::*;
#(
  parameter int unsigned FRAC = GainFracBits
) (
  input  fixed_point_t a,
  input  gain_t        b,
  output fixed_point_t y,
  output logic         sat_o
);

  localparam int unsigned W  = $bits(fixed_point_t);
  localparam int unsigned PW = W + $bits(gain_t);

  localparam logic signed [PW-1:0] Half = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] PMax = PW'(FixedPointMax);
  localparam logic signed [PW-1:0] PMin = PW'(FixedPointMin);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;

  always_comb begin
    prod  = a * b;
    rnd   = (prod + Half) >>> FRAC;
    sat_o = 1'b0;
    y     = rnd[W-1:0];
    if (rnd > PMax) begin
      y     = FixedPointMax;
      sat_o = 1'b1;
    end else if (rnd < PMin) begin
      y     = FixedPointMin;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/rms_gain.sv
// RMSNorm weight step: scales the shared activation vector in place by a
// per-channel gain register file. Optional RMS_GAIN_SAT_CNT_EN adds sat_cnt_o.
module rms_gain
  import config_pkg::*;
#(
  parameter int unsigned D         = config_pkg::D,
  parameter int unsigned GAIN_FRAC = GainFracBits
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic         in_ready_o,
  input  logic         in_start_i,
  output logic         done_o,
  output DI_t          vector_addr_o,
  output logic         vector_w_en_o,
  output fixed_point_t vector_w_data_o,
  input  fixed_point_t vector_r_data_i,
  input  logic         gain_w_en_i,
  input  DI_t          gain_w_addr_i,
  input  gain_t        gain_w_data_i
`ifdef RMS_GAIN_SAT_CNT_EN
  ,
  output logic [$clog2(D):0] sat_cnt_o
`endif
);

  rms_gain_state_e state_q, state_d;
  DI_t             index_q, index_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;

  gain_t           gain_q [D];
  fixed_point_t    mul_y, y_q;
  logic            mul_sat, sat_q;

  always_ff @(posedge clk_i) begin
    if (gain_w_en_i) gain_q[gain_w_addr_i] <= gain_w_data_i;
  end

  fixed_mul_round_sat #(
    .FRAC(GAIN_FRAC)
  ) u_mul (
    .a    (vector_r_data_i),
    .b    (gain_q[index_q]),
    .y    (mul_y),
    .sat_o(mul_sat)
  );

  // Rounded/saturated result is registered instead of the raw product;
  // the written value and its timing are the same.
  always_ff @(posedge clk_i) begin
    if (state_q == READ) begin
      y_q   <= mul_y;
      sat_q <= mul_sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      index_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    done_d        = 1'b0;
    valid_d       = 1'b0;
    in_ready_o    = 1'b0;
    vector_w_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_start_i) begin
          index_d = '0;
          state_d = READ;
        end
      end
      READ: begin
        valid_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        // Reset in a WRITE cycle must suppress that cycle's write too.
        vector_w_en_o = valid_q & rst_ni;
        if (index_q == DI_t'(D - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          index_d = index_q + DI_t'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vector_addr_o   = index_q;
  assign vector_w_data_o = y_q;
  assign done_o          = done_q;

`ifdef RMS_GAIN_SAT_CNT_EN
  logic [$clog2(D):0] sat_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sat_cnt_q <= '0;
    end else if (in_ready_o && in_start_i) begin
      sat_cnt_q <= '0;
    end else if (vector_w_en_o && sat_q) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_rms_gain.sv
// Directed bench for rms_gain with a behavioural vector memory.
module tb_rms_gain;
  import config_pkg::*;

  localparam int PassLat = 2 * D + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_ready, done;
  DI_t          vaddr;
  logic         vwe;
  fixed_point_t vwdata, vrdata;
  logic         gain_we = 1'b0;
  DI_t          gain_a = '0;
  gain_t        gain_d = '0;
`ifdef RMS_GAIN_SAT_CNT_EN
  logic [$clog2(D):0] sat_cnt;
`endif

  fixed_point_t mem [D];
  logic         tb_we = 1'b0;
  DI_t          tb_a = '0;
  fixed_point_t tb_d = '0;
  logic         cnt_clr = 1'b0;
  int           wr_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rms_gain dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_ready_o     (in_ready),
    .in_start_i     (start),
    .done_o         (done),
    .vector_addr_o  (vaddr),
    .vector_w_en_o  (vwe),
    .vector_w_data_o(vwdata),
    .vector_r_data_i(vrdata),
    .gain_w_en_i    (gain_we),
    .gain_w_addr_i  (gain_a),
    .gain_w_data_i  (gain_d)
`ifdef RMS_GAIN_SAT_CNT_EN
    ,
    .sat_cnt_o      (sat_cnt)
`endif
  );

  assign vrdata = mem[vaddr];

  always @(posedge clk) begin
    if (vwe) mem[vaddr] <= vwdata;
    else if (tb_we) mem[tb_a] <= tb_d;
    if (cnt_clr) wr_cnt <= 0;
    else if (vwe) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_elem(input int k, input int x, input int g);
    tb_we = 1'b1; tb_a = DI_t'(k); tb_d = fixed_point_t'(x);
    gain_we = 1'b1; gain_a = DI_t'(k); gain_d = gain_t'(g);
    @(negedge clk);
    tb_we = 1'b0; gain_we = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic wait_done(input int pulse_at, input bit hold, input int gw_at,
                           input int gw_a, input int gw_d,
                           output int lat, output bit rdy_seen);
    lat = 1; rdy_seen = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      start   = hold || (lat == pulse_at);
      gain_we = (lat == gw_at);
      gain_a  = DI_t'(gw_a);
      gain_d  = gain_t'(gw_d);
      @(negedge clk);
      lat++;
    end
    gain_we = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit rdy;

    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_wen", vwe, 0);
    rst_n = 1'b1;

    // identity: unit gains over a signed ramp
    for (int k = 0; k < D; k++) set_elem(k, k - D / 2, 256);
    kick();
    wait_done(-1, 1'b0, -1, 0, 0, lat, rdy);
    check("id_latency", lat, PassLat);
    check("id_ready_low", rdy, 0);
    check("id_writes", wr_cnt, D);
    for (int k = 0; k < D; k++) check("id_mem", mem[k], k - D / 2);
    @(negedge clk);
    check("id_done_pulse", done, 0);
    check("id_ready_back", in_ready, 1);
`ifdef RMS_GAIN_SAT_CNT_EN
    check("id_satcnt", sat_cnt, 0);
`endif

    // scaling, rounding and saturation
    set_elem(0, 3, 128);
    set_elem(1, 320, -512);
    set_elem(2, 1000, 0);
    set_elem(3, 32767, 512);
    set_elem(4, -32768, 512);
    set_elem(5, -3, 128);
    kick();
    wait_done(-1, 1'b0, -1, 0, 0, lat, rdy);
    check("sc_latency", lat, PassLat);
    check("sc_half_up", mem[0], 2);
    check("sc_neg2", mem[1], -640);
    check("sc_zero", mem[2], 0);
    check("sc_satmax", mem[3], 32767);
    check("sc_satmin", mem[4], -32768);
    check("sc_neg_half", mem[5], -1);
    check("sc_unity", mem[6], 6 - D / 2);
`ifdef RMS_GAIN_SAT_CNT_EN
    repeat (3) @(negedge clk);
    check("sc_satcnt", sat_cnt, 2);
`endif

    // start pulse mid-pass is ignored
    kick();
    wait_done(6, 1'b0, -1, 0, 0, lat, rdy);
    check("ign_latency", lat, PassLat);
    repeat (4) @(negedge clk);
    check("ign_writes", wr_cnt, D);
    check("ign_ready", in_ready, 1);

    // start held through done: second pass with no gap
    kick();
    wait_done(-1, 1'b1, -1, 0, 0, lat, rdy);
    check("b2b_lat1", lat, PassLat);
    @(negedge clk);
    start = 1'b0;
    check("b2b_nogap", in_ready, 0);
    wait_done(-1, 1'b0, -1, 0, 0, lat, rdy);
    check("b2b_lat2", lat, PassLat);
    check("b2b_writes", wr_cnt, 2 * D);

    // reset during WRITE of element D/2
    for (int k = 0; k < D; k++) set_elem(k, k + 1, 512);
    kick();
    start = 1'b0;
    repeat (2 * (D / 2) + 1) @(negedge clk);
    check("rst_in_write", vwe, 1);
    check("rst_addr", vaddr, D / 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    check("rst_writes", wr_cnt, D / 2);
    check("rst_last_done", mem[D / 2 - 1], 2 * (D / 2));
    check("rst_untouched", mem[D / 2], D / 2 + 1);
    check("rst_untouched_end", mem[D - 1], D);
    kick();
    wait_done(-1, 1'b0, -1, 0, 0, lat, rdy);
    check("rst_fresh_lat", lat, PassLat);
    check("rst_fresh_0", mem[0], 4);
    check("rst_fresh_mid", mem[D / 2], 2 * (D / 2 + 1));
    check("rst_fresh_end", mem[D - 1], 2 * D);

    // gain write to index 5 in the cycle element 5 is read
    for (int k = 0; k < D; k++) set_elem(k, 100 + k, 256);
    kick();
    wait_done(-1, 1'b0, 11, 5, 512, lat, rdy);
    check("col_latency", lat, PassLat);
    check("col_old_gain", mem[5], 105);
    check("col_neighbour", mem[6], 106);
    kick();
    wait_done(-1, 1'b0, -1, 0, 0, lat, rdy);
    check("col_new_gain", mem[5], 210);
    check("col_other", mem[4], 104);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
